cpu_clock_ctrl: RTL and testbench

//  Execution-rate controller between the board clock and the CPU core in FPGA_Top.

---
 rtl/cpu_clock_ctrl.sv | 116 +++++++++++
 tb/tb_cpu_clock_ctrl.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/cpu_clock_ctrl.sv
// CPU execution-rate controller: turns run/step/halt requests into a one-cycle
// clock enable for the core while the board clock itself stays undivided.
module cpu_clock_ctrl #(
  parameter int DIV_COUNT       = 100_000_000,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int CNT_W           = 16
) (
  input  logic             clk,
  input  logic             btnC,
  input  logic             run_sw,
  input  logic             step_btn,
  input  logic             cpu_halt,
  output logic             cpu_ce,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] ce_count
);

  localparam int PS_W = $clog2(DIV_COUNT);
  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(DIV_COUNT - 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    RUN    = 2'b01,
    STEP   = 2'b10,
    HALTED = 2'b11
  } state_t;

  state_t           cur;
  logic [PS_W-1:0]  presc;
  logic             run_meta, run_s;
  logic             step_meta, step_s;
  logic             step_db;
  logic [DB_W-1:0]  db_cnt;
  logic             step_pls;

  // Synchronizers plus debounce: the level only flips after a full run of
  // consecutive cycles that disagree with it; any agreeing cycle restarts the run.
  always_ff @(posedge clk) begin
    if (btnC) begin
      run_meta  <= 1'b0;
      run_s     <= 1'b0;
      step_meta <= 1'b0;
      step_s    <= 1'b0;
      step_db   <= 1'b0;
      db_cnt    <= '0;
    end else begin
      run_meta  <= run_sw;
      run_s     <= run_meta;
      step_meta <= step_btn;
      step_s    <= step_meta;
      if (step_s != step_db) begin
        if (db_cnt == DB_LAST) begin
          step_db <= step_s;
          db_cnt  <= '0;
        end else begin
          db_cnt <= db_cnt + DB_W'(1);
        end
      end else begin
        db_cnt <= '0;
      end
    end
  end

  // High in the cycle whose edge flips the debounced level from 0 to 1.
  assign step_pls = step_s && !step_db && (db_cnt == DB_LAST);

  always_ff @(posedge clk) begin
    if (btnC) begin
      cur      <= IDLE;
      cpu_ce   <= 1'b0;
      presc    <= '0;
      ce_count <= '0;
    end else begin
      if (cpu_ce)
        ce_count <= ce_count + CNT_W'(1);
      cpu_ce <= 1'b0;
      case (cur)
        IDLE: begin
          if (run_s) begin
            cur   <= RUN;
            presc <= '0;
          end else if (step_pls) begin
            cur    <= STEP;
            cpu_ce <= 1'b1;
          end
        end
        RUN: begin
          // Halt is checked first so a coincident tick never reaches the core.
          if (cpu_halt) begin
            cur   <= HALTED;
            presc <= '0;
          end else if (!run_s) begin
            cur   <= IDLE;
            presc <= '0;
          end else if (presc == PS_LAST) begin
            presc  <= '0;
            cpu_ce <= 1'b1;
          end else begin
            presc <= presc + PS_W'(1);
          end
        end
        STEP: cur <= IDLE;
        HALTED: begin
          if (!cpu_halt && !run_s)
            cur <= IDLE;
        end
        default: cur <= IDLE;
      endcase
    end
  end

  assign state = cur;

endmodule

// File: tb/tb_cpu_clock_ctrl.sv
// Bench for cpu_clock_ctrl: two instances (16-bit and 4-bit counters) share
// directed and random stimulus and are compared each cycle against a cycle-age model.
module tb_cpu_clock_ctrl;

  localparam int DEB = 3;
  localparam int IDLE_C = 0, RUN_C = 1, STEP_C = 2, HALT_C = 3;

  logic        clk = 1'b0;
  logic        btnC, run_sw, step_btn, cpu_halt;
  logic        ce_a, ce_b;
  logic [1:0]  st_a, st_b;
  logic [15:0] cnt_a;
  logic [3:0]  cnt_b;

  always #5 clk = ~clk;

  cpu_clock_ctrl #(.DIV_COUNT(4), .DEBOUNCE_CYCLES(DEB), .CNT_W(16)) dut_a (
    .clk(clk), .btnC(btnC), .run_sw(run_sw), .step_btn(step_btn),
    .cpu_halt(cpu_halt), .cpu_ce(ce_a), .state(st_a), .ce_count(cnt_a));

  cpu_clock_ctrl #(.DIV_COUNT(2), .DEBOUNCE_CYCLES(DEB), .CNT_W(4)) dut_b (
    .clk(clk), .btnC(btnC), .run_sw(run_sw), .step_btn(step_btn),
    .cpu_halt(cpu_halt), .cpu_ce(ce_b), .state(st_b), .ce_count(cnt_b));

  int checks = 0;
  int failures = 0;

  // Reference model: inputs delayed through queues, debounce as a run length,
  // RUN cadence derived from the number of cycles spent in RUN.
  int m_div[2]  = '{4, 2};
  int m_wrap[2] = '{65536, 16};
  int m_mode[2];
  int m_age[2];
  bit m_ce[2];
  int m_cnt[2];
  bit run_q[$];
  bit step_q[$];
  bit deb_level;
  int diff_run;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic modelEdge(input bit rst, input bit rsw, input bit sbtn, input bit halt);
    bit rs, ss, pls, new_ce;
    if (rst) begin
      run_q = '{1'b0, 1'b0};
      step_q = '{1'b0, 1'b0};
      deb_level = 1'b0;
      diff_run = 0;
      for (int i = 0; i < 2; i++) begin
        m_mode[i] = IDLE_C; m_age[i] = 0; m_ce[i] = 1'b0; m_cnt[i] = 0;
      end
      return;
    end
    rs = run_q.pop_front();
    run_q.push_back(rsw);
    ss = step_q.pop_front();
    step_q.push_back(sbtn);
    pls = 1'b0;
    if (ss != deb_level) begin
      diff_run++;
      if (diff_run == DEB) begin
        deb_level = ss;
        diff_run = 0;
        pls = deb_level;
      end
    end else begin
      diff_run = 0;
    end
    for (int i = 0; i < 2; i++) begin
      if (m_ce[i]) m_cnt[i] = (m_cnt[i] + 1) % m_wrap[i];
      new_ce = 1'b0;
      case (m_mode[i])
        IDLE_C: begin
          if (rs) begin m_mode[i] = RUN_C; m_age[i] = 0; end
          else if (pls) begin m_mode[i] = STEP_C; new_ce = 1'b1; end
        end
        RUN_C: begin
          if (halt) m_mode[i] = HALT_C;
          else if (!rs) m_mode[i] = IDLE_C;
          else begin
            m_age[i]++;
            new_ce = (m_age[i] % m_div[i] == 0);
          end
        end
        STEP_C: m_mode[i] = IDLE_C;
        default: if (!halt && !rs) m_mode[i] = IDLE_C;
      endcase
      m_ce[i] = new_ce;
    end
  endtask

  task automatic applyStimulus(input bit rst, input bit rsw, input bit sbtn, input bit halt);
    btnC = rst; run_sw = rsw; step_btn = sbtn; cpu_halt = halt;
    @(posedge clk);
    modelEdge(rst, rsw, sbtn, halt);
    #1;
    checkOutput("a.state", 32'(st_a), 32'(m_mode[0]));
    checkOutput("a.cpu_ce", 32'(ce_a), 32'(m_ce[0]));
    checkOutput("a.ce_count", 32'(cnt_a), 32'(m_cnt[0]));
    checkOutput("b.state", 32'(st_b), 32'(m_mode[1]));
    checkOutput("b.cpu_ce", 32'(ce_b), 32'(m_ce[1]));
    checkOutput("b.ce_count", 32'(cnt_b), 32'(m_cnt[1]));
  endtask

  initial begin
    bit rsw, sbtn, halt, rst;
    int waited;
    btnC = 1'b1; run_sw = 1'b0; step_btn = 1'b0; cpu_halt = 1'b0;

    $display("[TB] reset with inputs active");
    for (int i = 0; i < 5; i++) applyStimulus(1, 1, 1, 0);
    checkOutput("reset.state", 32'(st_a), 32'd0);

    $display("[TB] free run then stop");
    for (int i = 0; i < 60; i++) applyStimulus(0, 1, 0, 0);
    for (int i = 0; i < 8; i++) applyStimulus(0, 0, 0, 0);
    checkOutput("stop.state", 32'(st_a), 32'd0);

    $display("[TB] step glitches and held presses");
    applyStimulus(0, 0, 1, 0); applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 0, 1, 0); applyStimulus(0, 0, 0, 0);
    for (int i = 0; i < 6; i++) applyStimulus(0, 0, 0, 0);
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 20; i++) applyStimulus(0, 0, 1, 0);
      for (int i = 0; i < 10; i++) applyStimulus(0, 0, 0, 0);
    end

    $display("[TB] halt on the tick cycle");
    for (int i = 0; i < 5; i++) applyStimulus(1, 0, 0, 0);
    waited = 0;
    while (!(m_mode[0] == RUN_C && m_age[0] % 4 == 3 && m_age[0] > 4) && waited < 40) begin
      applyStimulus(0, 1, 0, 0);
      waited++;
    end
    checkOutput("halt.reached_tick", 32'(waited < 40), 32'd1);
    applyStimulus(0, 1, 0, 1);
    checkOutput("halt.state", 32'(st_a), 32'd3);
    for (int i = 0; i < 20; i++) applyStimulus(0, 1, (i % 10) < 6, 1);
    for (int i = 0; i < 6; i++) applyStimulus(0, 1, 0, 0);
    checkOutput("halt.hold", 32'(st_a), 32'd3);
    for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, 0);
    checkOutput("halt.exit", 32'(st_a), 32'd0);

    $display("[TB] counter wrap");
    for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 0);
    for (int i = 0; i < 40; i++) applyStimulus(0, 1, 0, 0);

    $display("[TB] reset mid-run");
    waited = 0;
    while (!(m_mode[0] == RUN_C && m_age[0] % 4 == 2) && waited < 40) begin
      applyStimulus(0, 1, 0, 0);
      waited++;
    end
    checkOutput("midrst.reached", 32'(waited < 40), 32'd1);
    applyStimulus(1, 1, 0, 0);
    checkOutput("midrst.count", 32'(cnt_a), 32'd0);
    for (int i = 0; i < 14; i++) applyStimulus(0, 1, 0, 0);

    $display("[TB] random stimulus");
    rsw = 1'b0; sbtn = 1'b0; halt = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 29) == 0) rsw = ~rsw;
      if ($urandom_range(0, 5) == 0) sbtn = ~sbtn;
      if ($urandom_range(0, 24) == 0) halt = ~halt;
      rst = ($urandom_range(0, 149) == 0);
      applyStimulus(rst, rsw, sbtn, halt);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
